// File: rtl/pos_emb_ctrl.sv
// Positional-embedding address controller.
// Walks a c/h/w pixel grid and issues paired input/position-table reads.
// It then issues one output write per read, in the same order.
// Reads and writes follow independent counter sets. The writes trail the
// reads by at most MAX_OUTST beats.
module pos_emb_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int PIXEL_BYTES = 64,
    parameter int MAX_OUTST   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_head,
    input  logic [CNT_W-1:0]  cfg_win,
    input  logic [CNT_W-1:0]  cfg_chg,
    input  logic [ADDR_W-1:0] cfg_pos_base,
    input  logic [ADDR_W-1:0] cfg_pos_line,
    input  logic [ADDR_W-1:0] cfg_din_base,
    input  logic [ADDR_W-1:0] cfg_din_surf,
    input  logic [ADDR_W-1:0] cfg_din_line,
    input  logic [ADDR_W-1:0] cfg_dout_base,
    input  logic [ADDR_W-1:0] cfg_dout_surf,
    input  logic [ADDR_W-1:0] cfg_dout_line,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_dat_addr,
    output logic [ADDR_W-1:0] rd_pos_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int PEND_W = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(PIXEL_BYTES);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_head, r_win, r_chg;
    logic [ADDR_W-1:0]   r_pos_line, r_din_surf, r_din_line, r_dout_surf, r_dout_line;
    logic                r_rd_valid, r_wr_valid, r_busy, r_done;
    logic [PEND_W-1:0]   r_pend;

    // Read-side walk: counters plus surface/row base registers for both tables
    logic [CNT_W-1:0]    r_rc, r_rh, r_rw;
    logic [ADDR_W-1:0]   r_rd_surf, r_rd_row, r_rd_dat, r_pos_row, r_rd_pos;

    // Write-side walk
    logic [CNT_W-1:0]    r_wc, r_wh, r_ww;
    logic [ADDR_W-1:0]   r_wr_surf, r_wr_row, r_wr_addr;

    logic                w_dims_ok, w_launch;
    logic                w_rd_acc, w_wr_acc;
    logic                w_rd_w_last, w_rd_h_last, w_rd_c_last, w_rd_last;
    logic                w_wr_w_last, w_wr_h_last, w_wr_c_last, w_wr_last;
    logic [PEND_W-1:0]   w_pend_next;
    logic [ADDR_W-1:0]   w_rd_row_inc, w_rd_surf_inc, w_pos_row_inc;
    logic [ADDR_W-1:0]   w_wr_row_inc, w_wr_surf_inc;

    assign w_dims_ok = (cfg_head != '0) && (cfg_win != '0) && (cfg_chg != '0);
    assign w_launch  = (r_state == S_IDLE) && start && w_dims_ok;

    assign w_rd_acc = r_rd_valid & rd_ready;
    assign w_wr_acc = r_wr_valid & wr_ready;

    assign w_rd_w_last = (r_rw == r_win - CNT_W'(1));
    assign w_rd_h_last = (r_rh == r_head - CNT_W'(1));
    assign w_rd_c_last = (r_rc == r_chg - CNT_W'(1));
    assign w_rd_last   = w_rd_w_last && w_rd_h_last && w_rd_c_last;

    assign w_wr_w_last = (r_ww == r_win - CNT_W'(1));
    assign w_wr_h_last = (r_wh == r_head - CNT_W'(1));
    assign w_wr_c_last = (r_wc == r_chg - CNT_W'(1));
    assign w_wr_last   = w_wr_w_last && w_wr_h_last && w_wr_c_last;

    assign w_rd_row_inc  = r_rd_row + r_din_line;
    assign w_rd_surf_inc = r_rd_surf + r_din_surf;
    assign w_pos_row_inc = r_pos_row + r_pos_line;
    assign w_wr_row_inc  = r_wr_row + r_dout_line;
    assign w_wr_surf_inc = r_wr_surf + r_dout_surf;

    assign rd_valid    = r_rd_valid;
    assign rd_dat_addr = r_rd_dat;
    assign rd_pos_addr = r_rd_pos;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign busy        = r_busy;
    assign done        = r_done;

    // Outstanding count after this cycle's handshakes; simultaneous accepts cancel
    always_comb begin
        w_pend_next = r_pend;
        if (w_rd_acc && !w_wr_acc) begin
            w_pend_next = r_pend + PEND_W'(1);
        end else if (!w_rd_acc && w_wr_acc) begin
            w_pend_next = r_pend - PEND_W'(1);
        end
    end

    // Track reads accepted but not yet written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // Job FSM: config latch, registered handshake valids, busy and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_win       <= '0;
            r_chg       <= '0;
            r_pos_line  <= '0;
            r_din_surf  <= '0;
            r_din_line  <= '0;
            r_dout_surf <= '0;
            r_dout_line <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_dims_ok) begin
                            r_head      <= cfg_head;
                            r_win       <= cfg_win;
                            r_chg       <= cfg_chg;
                            r_pos_line  <= cfg_pos_line;
                            r_din_surf  <= cfg_din_surf;
                            r_din_line  <= cfg_din_line;
                            r_dout_surf <= cfg_dout_surf;
                            r_dout_line <= cfg_dout_line;
                            r_busy      <= 1'b1;
                            r_rd_valid  <= 1'b0;
                            r_state     <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_wr_valid <= (w_pend_next != '0);
                    if (w_rd_acc && w_rd_last) begin
                        r_rd_valid <= 1'b0;
                        r_state    <= S_DRAIN;
                    end else begin
                        r_rd_valid <= (w_pend_next < PEND_MAX);
                    end
                end
                S_DRAIN: begin
                    r_wr_valid <= (w_pend_next != '0);
                    if (w_wr_acc && w_wr_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read address walk: w innermost, then h, then c.
    // The position row advances only when c crosses an odd->even boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rc      <= '0;
            r_rh      <= '0;
            r_rw      <= '0;
            r_rd_surf <= '0;
            r_rd_row  <= '0;
            r_rd_dat  <= '0;
            r_pos_row <= '0;
            r_rd_pos  <= '0;
        end else if (w_launch) begin
            r_rc      <= '0;
            r_rh      <= '0;
            r_rw      <= '0;
            r_rd_surf <= cfg_din_base;
            r_rd_row  <= cfg_din_base;
            r_rd_dat  <= cfg_din_base;
            r_pos_row <= cfg_pos_base;
            r_rd_pos  <= cfg_pos_base;
        end else if (w_rd_acc && !w_rd_last) begin
            if (!w_rd_w_last) begin
                r_rw     <= r_rw + CNT_W'(1);
                r_rd_dat <= r_rd_dat + PIX_STEP;
                r_rd_pos <= r_rd_pos + PIX_STEP;
            end else if (!w_rd_h_last) begin
                r_rw     <= '0;
                r_rh     <= r_rh + CNT_W'(1);
                r_rd_row <= w_rd_row_inc;
                r_rd_dat <= w_rd_row_inc;
                r_rd_pos <= r_pos_row;
            end else begin
                r_rw      <= '0;
                r_rh      <= '0;
                r_rc      <= r_rc + CNT_W'(1);
                r_rd_surf <= w_rd_surf_inc;
                r_rd_row  <= w_rd_surf_inc;
                r_rd_dat  <= w_rd_surf_inc;
                if (r_rc[0]) begin
                    r_pos_row <= w_pos_row_inc;
                    r_rd_pos  <= w_pos_row_inc;
                end else begin
                    r_rd_pos  <= r_pos_row;
                end
            end
        end
    end

    // Write address walk: same order as reads, on its own counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wc      <= '0;
            r_wh      <= '0;
            r_ww      <= '0;
            r_wr_surf <= '0;
            r_wr_row  <= '0;
            r_wr_addr <= '0;
        end else if (w_launch) begin
            r_wc      <= '0;
            r_wh      <= '0;
            r_ww      <= '0;
            r_wr_surf <= cfg_dout_base;
            r_wr_row  <= cfg_dout_base;
            r_wr_addr <= cfg_dout_base;
        end else if (w_wr_acc && !w_wr_last) begin
            if (!w_wr_w_last) begin
                r_ww      <= r_ww + CNT_W'(1);
                r_wr_addr <= r_wr_addr + PIX_STEP;
            end else if (!w_wr_h_last) begin
                r_ww      <= '0;
                r_wh      <= r_wh + CNT_W'(1);
                r_wr_row  <= w_wr_row_inc;
                r_wr_addr <= w_wr_row_inc;
            end else begin
                r_ww      <= '0;
                r_wh      <= '0;
                r_wc      <= r_wc + CNT_W'(1);
                r_wr_surf <= w_wr_surf_inc;
                r_wr_row  <= w_wr_surf_inc;
                r_wr_addr <= w_wr_surf_inc;
            end
        end
    end

endmodule
